// File: rtl/cfg_reg_master.sv
// Initiator for the config register bus: turns READ/WRITE/SET/CLEAR requests into
// register bus cycles and returns one response per request, optionally verifying writes.
module cfg_reg_master #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int VERIFY   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_address,
    output logic [DATA_W-1:0] reg_data_in,
    input  logic [DATA_W-1:0] reg_data_out
);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [ADDR_W:0] LP_NREGS  = NUM_REGS[ADDR_W:0];
    localparam bit              LP_VERIFY = (VERIFY != 0);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR, S_CHK, S_RSP} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_rdy;
    logic [1:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_mask;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic                w_accept;
    logic                w_bad;

    // r_rdy is a flop so req_ready stays low while reset is held
    assign w_accept = req_valid && r_rdy && (r_state == S_IDLE);
    assign w_bad    = ({1'b0, req_addr} >= LP_NREGS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_bad)                   w_next = S_RSP;
                    else if (req_op == OP_WRITE) w_next = S_WR;
                    else                         w_next = S_RD;
                end
            end
            S_RD:    w_next = (r_op == OP_READ) ? S_RSP : S_WR;
            S_WR:    w_next = LP_VERIFY ? S_CHK : S_RSP;
            S_CHK:   w_next = S_RSP;
            S_RSP:   w_next = rsp_ready ? S_IDLE : S_RSP;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = r_rdy;
        rsp_valid   = (r_state == S_RSP);
        reg_write   = (r_state == S_WR);
        reg_address = r_addr;
        reg_data_in = r_wdata;
        rsp_data    = r_rsp_data;
        rsp_err     = r_rsp_err;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdy      <= 1'b0;
            r_op       <= OP_READ;
            r_addr     <= '0;
            r_mask     <= '0;
            r_wdata    <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rdy <= (w_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= req_op;
                        r_mask <= req_data;
                        if (w_bad) begin
                            // bad address never touches the bus, address holds
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end else begin
                            r_addr <= req_addr;
                            if (req_op == OP_WRITE) r_wdata <= req_data;
                        end
                    end
                end
                S_RD: begin
                    r_rsp_data <= reg_data_out;
                    r_rsp_err  <= 1'b0;
                    if (r_op == OP_SET)   r_wdata <= reg_data_out | r_mask;
                    if (r_op == OP_CLEAR) r_wdata <= reg_data_out & ~r_mask;
                end
                S_WR: begin
                    r_rsp_data <= r_wdata;
                    r_rsp_err  <= 1'b0;
                end
                S_CHK: begin
                    r_rsp_err <= (reg_data_out != r_wdata);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_reg_master.sv
// Bench for cfg_reg_master: a behavioural register-file model predicts every response.
module tb_cfg_reg_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0, rsp_err, reg_write;
    logic [1:0]  req_op = 2'b00;
    logic [2:0]  req_addr = 3'd0, reg_address;
    logic [15:0] req_data = 16'h0, rsp_data, reg_data_in, reg_data_out;

    // second instance with 6 registers for bad-address handling
    logic        b_req_valid = 1'b0, b_req_ready, b_rsp_valid, b_rsp_ready = 1'b0, b_rsp_err, b_reg_write;
    logic [1:0]  b_req_op = 2'b00;
    logic [2:0]  b_req_addr = 3'd0, b_reg_address;
    logic [15:0] b_req_data = 16'h0, b_rsp_data, b_reg_data_in, b_reg_data_out;

    logic [15:0] bus_mem [8] = '{16'hFFFF, 16'h0000, 16'h1234, 16'h0000,
                                 16'hABCD, 16'h0000, 16'h0000, 16'h0001};
    logic [15:0] mdl [8]     = '{16'hFFFF, 16'h0000, 16'h1234, 16'h0000,
                                 16'hABCD, 16'h0000, 16'h0000, 16'h0001};
    logic        ro_en = 1'b0;
    int          tests = 0, fails = 0, last_wait = 0;

    cfg_reg_master #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(8), .VERIFY(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .reg_write(reg_write), .reg_address(reg_address), .reg_data_in(reg_data_in),
        .reg_data_out(reg_data_out));

    cfg_reg_master #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(6), .VERIFY(1)) dut6 (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_op(b_req_op), .req_addr(b_req_addr), .req_data(b_req_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .reg_write(b_reg_write), .reg_address(b_reg_address), .reg_data_in(b_reg_data_in),
        .reg_data_out(b_reg_data_out));

    // register block: comb read, write on edge; register 1 can be made read-only
    assign reg_data_out   = bus_mem[reg_address];
    assign b_reg_data_out = {8'hA5, 5'h00, b_reg_address};
    always @(posedge clk)
        if (reg_write && !(ro_en && reg_address == 3'd1)) bus_mem[reg_address] <= reg_data_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic xact(input logic [1:0] op, input logic [2:0] a, input logic [15:0] d, input int hold);
        logic [15:0] old, wv, rb, exp_d, sd;
        logic        exp_e, se;
        int          exp_lat, exp_wr, lat, wr, n;
        old = mdl[a];
        if (op == 2'b00) begin
            exp_d = old; exp_e = 1'b0; exp_lat = 1; exp_wr = 0;
        end else begin
            wv = (op == 2'b01) ? d : (op == 2'b10) ? (old | d) : (old & ~d);
            rb = (ro_en && a == 3'd1) ? old : wv;
            mdl[a] = rb;
            exp_d = wv; exp_e = (rb != wv);
            exp_lat = ((op == 2'b01) ? 1 : 2) + 1; exp_wr = 1;
        end
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        last_wait = n;
        chk("ready_wait", 32'(n < 20), 1);
        req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
        @(negedge clk);
        req_valid = 1'b0; req_op = 2'($urandom); req_addr = 3'($urandom); req_data = 16'($urandom);
        chk("busy_ready", req_ready, 0);
        lat = 0; wr = int'(reg_write);
        while (!rsp_valid && lat < 12) begin @(negedge clk); lat++; wr += int'(reg_write); end
        chk("latency", lat, exp_lat);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_err", rsp_err, exp_e);
        chk("wr_cycles", wr, exp_wr);
        sd = rsp_data; se = rsp_err;
        if (hold > 0) begin
            req_valid = 1'b1; req_op = 2'b01; req_addr = 3'd2; req_data = 16'hDEAD;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_stable", {rsp_valid, req_ready, reg_write, rsp_err, rsp_data}, {3'b100, se, sd});
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b0;
        chk("released", {rsp_valid, req_ready}, 2'b01);
    endtask

    task automatic xact6(input logic [1:0] op, input logic [2:0] a);
        logic [15:0] exp_d;
        logic        exp_e;
        logic [2:0]  pre_addr;
        int          lat, wr, n;
        exp_e = (a >= 3'd6);
        exp_d = exp_e ? 16'h0000 : ((op == 2'b00) ? {8'hA5, 5'h00, a} : 16'h0000);
        pre_addr = b_reg_address;
        n = 0;
        while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
        chk("b_ready_wait", 32'(n < 20), 1);
        b_req_valid = 1'b1; b_req_op = op; b_req_addr = a; b_req_data = 16'h0;
        @(negedge clk);
        b_req_valid = 1'b0;
        lat = 0; wr = int'(b_reg_write);
        while (!b_rsp_valid && lat < 12) begin @(negedge clk); lat++; wr += int'(b_reg_write); end
        chk("b_latency", lat, exp_e ? 0 : 1);
        chk("b_rsp", {b_rsp_err, b_rsp_data}, {exp_e, exp_d});
        chk("b_wr_cycles", wr, 0);
        chk("b_addr", b_reg_address, exp_e ? pre_addr : a);
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_rsp_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_outs", {req_ready, rsp_valid, rsp_err, reg_write, rsp_data, reg_address, reg_data_in},
            '0);
        reset = 1'b1;

        xact(2'b00, 3'd0, 16'h0, 0);
        xact(2'b00, 3'd4, 16'h0, 0);
        xact(2'b01, 3'd6, 16'h5A5A, 0);
        xact(2'b00, 3'd6, 16'h0, 0);
        xact(2'b10, 3'd7, 16'h8000, 0);
        xact(2'b11, 3'd4, 16'h000F, 0);

        for (int a = 0; a < 8; a++)
            for (int k = 0; k < 16; k++) begin
                xact(2'b01, 3'(a), 16'h1 << k, 0);
                xact(2'b00, 3'(a), 16'h0, 0);
            end
        for (int a = 0; a < 8; a++) begin
            xact(2'b01, 3'(a), 16'h0000, 0); xact(2'b00, 3'(a), 16'h0, 0);
            xact(2'b01, 3'(a), 16'hFFFF, 0); xact(2'b00, 3'(a), 16'h0, 0);
        end

        xact(2'b00, 3'd2, 16'h0, 5);
        xact(2'b01, 3'd3, 16'h3C3C, 0);
        chk("pend_accept", last_wait, 0);
        xact(2'b10, 3'd5, 16'h0000, 0);

        ro_en = 1'b1;
        xact(2'b01, 3'd1, 16'h00FF, 0);
        xact(2'b01, 3'd1, mdl[1], 0);
        ro_en = 1'b0;

        for (int i = 0; i < 200; i++) begin
            ro_en = ($urandom_range(0, 3) == 0);
            xact(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 16'($urandom), $urandom_range(0, 2));
        end
        ro_en = 1'b0;

        // reset while a SET is in its write cycle
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_op = 2'b10; req_addr = 3'd2; req_data = 16'hF000;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("wr_before_rst", reg_write, 1);
        #2 reset = 1'b0;
        #1 chk("rst_abort", {reg_write, rsp_valid, req_ready}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        chk("no_write", bus_mem[2], mdl[2]);
        repeat (3) @(negedge clk);
        chk("no_rsp", rsp_valid, 0);
        xact(2'b00, 3'd2, 16'h0, 0);

        xact6(2'b00, 3'd5);
        xact6(2'b00, 3'd7);
        xact6(2'b01, 3'd6);
        xact6(2'b00, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
